// File: rtl/mole_round_controller_pkg.sv
// Shared definitions for the whack-a-mole round controller: FSM states,
// default constants, LFSR taps and the mole index reduction helper.
package mole_round_controller_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SPAWN  = 3'd1,
    S_ACTIVE = 3'd2,
    S_HIT    = 3'd3,
    S_WAIT   = 3'd4,
    S_MISS   = 3'd5,
    S_OVER   = 3'd6
  } state_t;

  localparam int          DEF_START_VAL = 5;
  localparam logic [15:0] DEF_LFSR_SEED = 16'hACE1;

  // Bit positions of the polynomial taps 16,14,13,11 in a [15:0] register
  localparam int LFSR_TAP_A = 15;
  localparam int LFSR_TAP_B = 13;
  localparam int LFSR_TAP_C = 12;
  localparam int LFSR_TAP_D = 10;

  // Low nibble reduced modulo the mole count by repeated subtraction
  function automatic logic [3:0] mole_index(input logic [15:0] lfsr, input int unsigned numMoles);
    logic [4:0] rem;
    rem = {1'b0, lfsr[3:0]};
    for (int i = 0; i < 16; i++) begin
      if (rem >= numMoles[4:0]) rem = rem - numMoles[4:0];
    end
    return rem[3:0];
  endfunction

endpackage

// File: rtl/mole_round_controller_if.sv
// Game bus between the countdown/button side and the round controller;
// the controller sits on the slave modport.
interface mole_round_controller_if #(
  parameter int COUNT_W   = 32,
  parameter int NUM_MOLES = 4,
  parameter int SCORE_W   = 8
);
  logic [COUNT_W-1:0]   count_in;
  logic                 start;
  logic [NUM_MOLES-1:0] btn;
  logic [NUM_MOLES-1:0] mole_led;
  logic [SCORE_W-1:0]   score;
  logic [SCORE_W-1:0]   misses;
  logic [SCORE_W-1:0]   round_num;
  logic                 busy;
  logic                 game_over;

  modport master (
    output count_in, start, btn,
    input  mole_led, score, misses, round_num, busy, game_over
  );

  modport slave (
    input  count_in, start, btn,
    output mole_led, score, misses, round_num, busy, game_over
  );
endinterface

// File: rtl/mole_round_controller_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) with synchronous active-low
// reset to a loadable seed; shared by randomised game blocks.
module lfsr16
  import mole_round_controller_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] r_q;
  logic        w_feedback;

  assign w_feedback = r_q[LFSR_TAP_A] ^ r_q[LFSR_TAP_B] ^ r_q[LFSR_TAP_C] ^ r_q[LFSR_TAP_D];
  assign q = r_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_q <= seed;
    end else if (en) begin
      r_q <= {r_q[14:0], w_feedback};
    end
  end

endmodule

// File: rtl/mole_round_controller.sv
// Whack-a-mole round sequencer: uses countdown wraps as round boundaries,
// spawns an LFSR-chosen mole each round and tracks hits, misses and rounds.
module mole_round_controller
  import mole_round_controller_pkg::*;
#(
  parameter int          COUNT_W    = 32,
  parameter int          START_VAL  = DEF_START_VAL,
  parameter int          NUM_MOLES  = 4,
  parameter int          NUM_ROUNDS = 10,
  parameter int          MAX_MISSES = 3,
  parameter int          SCORE_W    = 8,
  parameter logic [15:0] LFSR_SEED  = DEF_LFSR_SEED
) (
  input logic clk,
  input logic reset,
  mole_round_controller_if.slave bus
);

  state_t               r_state;
  logic [COUNT_W-1:0]   r_count_q;
  logic [NUM_MOLES-1:0] r_btn_q;
  logic [NUM_MOLES-1:0] r_mole_led;
  logic [SCORE_W-1:0]   r_score;
  logic [SCORE_W-1:0]   r_misses;
  logic [SCORE_W-1:0]   r_round_num;
  logic                 r_busy;
  logic                 r_game_over;

  logic [15:0]          w_lfsr;
  logic                 w_wrap;
  logic [NUM_MOLES-1:0] w_edge;
  logic                 w_hit;
  logic [NUM_MOLES-1:0] w_onehot;
  logic                 w_last_round;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .seed  (LFSR_SEED),
    .q     (w_lfsr)
  );

  assign w_wrap       = (r_count_q == COUNT_W'(1)) && (bus.count_in == COUNT_W'(START_VAL));
  assign w_edge       = bus.btn & ~r_btn_q;
  // The displayed LED is one-hot of the latched index, so masking edges with it selects edge[index]
  assign w_hit        = |(w_edge & r_mole_led);
  assign w_onehot     = NUM_MOLES'(1) << mole_index(w_lfsr, NUM_MOLES);
  assign w_last_round = (r_round_num == SCORE_W'(NUM_ROUNDS));

  assign bus.mole_led  = r_mole_led;
  assign bus.score     = r_score;
  assign bus.misses    = r_misses;
  assign bus.round_num = r_round_num;
  assign bus.busy      = r_busy;
  assign bus.game_over = r_game_over;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count_q <= COUNT_W'(START_VAL);
      r_btn_q   <= '0;
    end else begin
      r_count_q <= bus.count_in;
      r_btn_q   <= bus.btn;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_mole_led  <= '0;
      r_score     <= '0;
      r_misses    <= '0;
      r_round_num <= '0;
      r_busy      <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_OVER: begin
          if (bus.start) begin
            r_score     <= '0;
            r_misses    <= '0;
            r_round_num <= '0;
            r_busy      <= 1'b1;
            r_game_over <= 1'b0;
            r_state     <= S_SPAWN;
          end
        end
        S_SPAWN: begin
          r_mole_led  <= w_onehot;
          r_round_num <= r_round_num + SCORE_W'(1);
          r_state     <= S_ACTIVE;
        end
        S_ACTIVE: begin
          if (w_hit) r_state <= S_HIT;
          else if (w_wrap) r_state <= S_MISS;
        end
        S_HIT: begin
          if (r_score != '1) r_score <= r_score + SCORE_W'(1);
          r_mole_led <= '0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (w_wrap) begin
            if (w_last_round) begin
              r_busy      <= 1'b0;
              r_game_over <= 1'b1;
              r_state     <= S_OVER;
            end else begin
              r_state <= S_SPAWN;
            end
          end
        end
        S_MISS: begin
          r_misses   <= r_misses + SCORE_W'(1);
          r_mole_led <= '0;
          // The wrap that caused the miss already marks the next round boundary
          if ((r_misses + SCORE_W'(1) == SCORE_W'(MAX_MISSES)) || w_last_round) begin
            r_busy      <= 1'b0;
            r_game_over <= 1'b1;
            r_state     <= S_OVER;
          end else begin
            r_state <= S_SPAWN;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mole_round_controller.sv
// Directed bench for mole_round_controller: table-driven games plus
// hand-written sequences for same-cycle hit/wrap, held buttons and a full game.
module tb_mole_round_controller;
  import mole_round_controller_pkg::*;

  localparam int NM = 4;

  typedef struct {
    int cnt;
    bit st;
    int sel;
    int hold;
    int eScore;
    int eMiss;
    int eRound;
    bit eBusy;
    bit eOver;
    bit eMole;
  } vec_t;

  logic clk;
  logic reset;
  int nChecks = 0;
  int nFail   = 0;

  logic [15:0]   mLfsr = 16'hACE1;
  logic [15:0]   mPrev = 16'hACE1;
  logic [NM-1:0] prevLed = '0;
  logic [NM-1:0] curMole = '0;
  logic [NM-1:0] wrongMask;
  logic [NM-1:0] heldMask;
  vec_t vecs[$];

  mole_round_controller_if #(.COUNT_W(32), .NUM_MOLES(NM), .SCORE_W(8)) bus ();

  mole_round_controller #(
    .COUNT_W(32), .START_VAL(5), .NUM_MOLES(NM), .NUM_ROUNDS(10),
    .MAX_MISSES(3), .SCORE_W(8), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR; mPrev holds the value the design saw at the latest edge
  always @(posedge clk) begin
    mPrev <= mLfsr;
    if (!reset) mLfsr <= 16'hACE1;
    else mLfsr <= {mLfsr[14:0], mLfsr[15] ^ mLfsr[13] ^ mLfsr[12] ^ mLfsr[10]};
  end

  task automatic applyStimulus(input int cnt, input bit st, input logic [NM-1:0] b);
    bus.count_in = 32'(cnt);
    bus.start    = st;
    bus.btn      = b;
  endtask

  task automatic tick();
    logic [NM-1:0] expMask;
    @(posedge clk);
    #1;
    if (bus.mole_led != '0 && prevLed == '0) begin
      expMask = NM'(1) << (mPrev[3:0] % NM);
      nChecks++;
      if (bus.mole_led !== expMask) begin
        nFail++;
        $display("[TB] FAIL mole index: got mole_led=%b, want %b", bus.mole_led, expMask);
      end
      curMole = expMask;
    end
    prevLed = bus.mole_led;
  endtask

  task automatic checkOutput(input string name, input int eScore, input int eMiss,
                             input int eRound, input bit eBusy, input bit eOver, input bit eMole);
    nChecks++;
    if (bus.score !== 8'(eScore) || bus.misses !== 8'(eMiss) || bus.round_num !== 8'(eRound) ||
        bus.busy !== eBusy || bus.game_over !== eOver || ((bus.mole_led != '0) !== eMole)) begin
      nFail++;
      $display("[TB] FAIL %s: got score=%0d misses=%0d round=%0d busy=%b over=%b mole_led=%b, want score=%0d misses=%0d round=%0d busy=%b over=%b moleShown=%b",
               name, bus.score, bus.misses, bus.round_num, bus.busy, bus.game_over, bus.mole_led,
               eScore, eMiss, eRound, eBusy, eOver, eMole);
    end
  endtask

  function automatic void addVec(input int cnt, input bit st, input int sel, input int hold,
                                 input int s, input int m, input int r,
                                 input bit b, input bit g, input bit mo);
    vec_t v;
    v = '{cnt, st, sel, hold, s, m, r, b, g, mo};
    vecs.push_back(v);
  endfunction

  function automatic logic [NM-1:0] selMask(input int sel);
    if (sel == 1) return curMole;
    if (sel == 2) return {curMole[NM-2:0], curMole[NM-1]};
    return '0;
  endfunction

  task automatic runTable(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].cnt, vecs[i].st, selMask(vecs[i].sel));
      repeat (vecs[i].hold) tick();
      checkOutput($sformatf("%s row %0d", tag, i), vecs[i].eScore, vecs[i].eMiss,
                  vecs[i].eRound, vecs[i].eBusy, vecs[i].eOver, vecs[i].eMole);
    end
    vecs.delete();
  endtask

  task automatic countDown(input logic [NM-1:0] mask);
    for (int c = 4; c >= 1; c--) begin
      applyStimulus(c, 1'b0, mask);
      repeat (3) tick();
    end
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(5, 1'b0, '0);
    repeat (3) tick();
    checkOutput("power-on reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b1;

    // Game 1: hit at count 3, next mole only after the following wrap
    addVec(5, 1, 0, 1, 0, 0, 0, 1, 0, 0);
    addVec(5, 0, 0, 1, 0, 0, 1, 1, 0, 1);
    addVec(4, 0, 0, 3, 0, 0, 1, 1, 0, 1);
    addVec(3, 0, 1, 1, 0, 0, 1, 1, 0, 1);
    addVec(3, 0, 1, 1, 1, 0, 1, 1, 0, 0);
    addVec(2, 0, 1, 3, 1, 0, 1, 1, 0, 0);
    addVec(1, 0, 0, 3, 1, 0, 1, 1, 0, 0);
    addVec(5, 0, 0, 1, 1, 0, 1, 1, 0, 0);
    addVec(5, 0, 0, 1, 1, 0, 2, 1, 0, 1);
    addVec(4, 0, 0, 2, 1, 0, 2, 1, 0, 1);
    runTable("hit game");

    // Reset in the middle of ACTIVE
    reset = 1'b0;
    tick();
    checkOutput("reset in active, first edge", 0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    checkOutput("reset in active, held", 0, 0, 0, 0, 0, 0);
    reset = 1'b1;

    // Game 2: three straight misses end the game, then restart from OVER
    addVec(5, 1, 0, 1, 0, 0, 0, 1, 0, 0);
    addVec(5, 0, 0, 1, 0, 0, 1, 1, 0, 1);
    addVec(5, 1, 0, 1, 0, 0, 1, 1, 0, 1);
    for (int r = 1; r <= 3; r++) begin
      for (int c = 4; c >= 1; c--) addVec(c, 0, 0, 3, 0, r - 1, r, 1, 0, 1);
      addVec(5, 0, 0, 1, 0, r - 1, r, 1, 0, 1);
      if (r < 3) begin
        addVec(5, 0, 0, 1, 0, r, r, 1, 0, 0);
        addVec(5, 0, 0, 1, 0, r, r + 1, 1, 0, 1);
      end else begin
        addVec(5, 0, 0, 1, 0, 3, 3, 0, 1, 0);
      end
    end
    addVec(5, 0, 0, 3, 0, 3, 3, 0, 1, 0);
    addVec(4, 0, 1, 3, 0, 3, 3, 0, 1, 0);
    addVec(5, 1, 0, 1, 0, 0, 0, 1, 0, 0);
    addVec(5, 0, 0, 1, 0, 0, 1, 1, 0, 1);
    runTable("miss game");

    // Game 3, round 1: correct edge lands on the wrap cycle
    countDown('0);
    applyStimulus(5, 1'b0, curMole);
    tick();
    checkOutput("edge with wrap", 0, 0, 1, 1, 0, 1);
    tick();
    checkOutput("edge with wrap scores", 1, 0, 1, 1, 0, 0);
    applyStimulus(5, 1'b0, '0);
    repeat (3) tick();
    checkOutput("waits for next wrap", 1, 0, 1, 1, 0, 0);
    countDown('0);
    applyStimulus(5, 1'b0, '0);
    tick();
    checkOutput("spawn after wrap", 1, 0, 1, 1, 0, 0);
    tick();
    checkOutput("round 2 shown", 1, 0, 2, 1, 0, 1);

    // Round 2: wrong button first, then correct button held into round 3
    wrongMask = {curMole[NM-2:0], curMole[NM-1]};
    applyStimulus(4, 1'b0, wrongMask);
    repeat (2) tick();
    applyStimulus(4, 1'b0, '0);
    tick();
    checkOutput("wrong button ignored", 1, 0, 2, 1, 0, 1);
    heldMask = curMole;
    applyStimulus(3, 1'b0, heldMask);
    repeat (2) tick();
    checkOutput("round 2 hit", 2, 0, 2, 1, 0, 0);
    applyStimulus(2, 1'b0, heldMask);
    repeat (3) tick();
    applyStimulus(1, 1'b0, heldMask);
    repeat (3) tick();
    applyStimulus(5, 1'b0, heldMask);
    repeat (2) tick();
    checkOutput("held into round 3", 2, 0, 3, 1, 0, 1);
    countDown(heldMask);
    applyStimulus(5, 1'b0, heldMask);
    repeat (2) tick();
    checkOutput("held button no rehit", 2, 1, 3, 1, 0, 0);
    applyStimulus(5, 1'b0, '0);
    tick();
    checkOutput("round 4 shown", 2, 1, 4, 1, 0, 1);

    // Rounds 4..10 all hit; the wrap after round 10 ends the game
    for (int r = 4; r <= 10; r++) begin
      applyStimulus(4, 1'b0, '0);
      repeat (3) tick();
      applyStimulus(3, 1'b0, curMole);
      repeat (2) tick();
      checkOutput($sformatf("hit round %0d", r), r - 1, 1, r, 1, 0, 0);
      applyStimulus(2, 1'b0, '0);
      repeat (3) tick();
      applyStimulus(1, 1'b0, '0);
      repeat (3) tick();
      applyStimulus(5, 1'b0, '0);
      tick();
      if (r < 10) begin
        tick();
        checkOutput($sformatf("round %0d shown", r + 1), r - 1, 1, r + 1, 1, 0, 1);
      end else begin
        checkOutput("game over after round 10", 9, 1, 10, 0, 1, 0);
      end
    end
    repeat (3) tick();
    checkOutput("over holds counters", 9, 1, 10, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
